// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter between byte sources,
// with per-requester message lock and a programmable tx_done watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int REQ_IDX_WIDTH = 2,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*8-1:0]     req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     tx_te,
    output logic [7:0]               tx_dr,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [REQ_IDX_WIDTH-1:0] grant_idx,
    output logic                     timeout_err,
    output logic [7:0]               timeout_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t state;
    logic lock, last_flag, rr_found, lock_hit, grant;
    logic [REQ_IDX_WIDTH-1:0] lock_idx, last_grant, rr_idx, pick, j;
    logic [7:0] pick_data;
    logic [TIMEOUT_WIDTH-1:0] wd_cnt, wd_nxt;
    // Scan downward so the candidate closest after last_grant is assigned last and wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = REQ_IDX_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (req[j]) begin
                rr_found = 1'b1;
                rr_idx = j;
            end
        end
        lock_hit = lock && req[lock_idx];
        pick = lock_hit ? lock_idx : rr_idx;
        grant = enable && (lock_hit || rr_found);
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            pick_data = (pick == REQ_IDX_WIDTH'(i)) ? req_data[8*i +: 8] : pick_data;
        wd_nxt = wd_cnt + TIMEOUT_WIDTH'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            lock <= 1'b0;
            lock_idx <= '0;
            last_grant <= REQ_IDX_WIDTH'(NUM_REQ - 1);
            last_flag <= 1'b0;
            wd_cnt <= '0;
            ack <= '0;
            tx_te <= 1'b0;
            tx_dr <= '0;
            busy <= 1'b0;
            grant_idx <= '0;
            timeout_err <= 1'b0;
            timeout_count <= '0;
        end else begin
            tx_te <= 1'b0;
            ack <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    if (lock && !req[lock_idx]) lock <= 1'b0;
                    if (grant) begin
                        tx_dr <= pick_data;
                        tx_te <= 1'b1;
                        ack <= NUM_REQ'(1) << pick;
                        last_grant <= pick;
                        grant_idx <= pick;
                        last_flag <= req_last[pick];
                        busy <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wd_cnt <= wd_nxt;
                    if (tx_done) begin
                        lock <= !last_flag;
                        lock_idx <= grant_idx;
                        busy <= 1'b0;
                        state <= IDLE;
                    end else if (timeout_cycles != '0 && wd_nxt >= timeout_cycles) begin
                        timeout_err <= 1'b1;
                        timeout_count <= (timeout_count == 8'hFF) ? timeout_count : timeout_count + 8'd1;
                        lock <= 1'b0;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;
    logic clk = 1'b0, reset_n, enable, tx_done;
    logic [23:0] timeout_cycles;
    logic [3:0] req, req_last, ack;
    logic [31:0] req_data;
    logic tx_te, busy, timeout_err;
    logic [7:0] tx_dr, timeout_count;
    logic [1:0] grant_idx;
    int n_cmp = 0, n_bad = 0;

    uart_tx_arbiter dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .timeout_cycles(timeout_cycles),
        .req(req), .req_last(req_last), .req_data(req_data), .ack(ack), .tx_te(tx_te),
        .tx_dr(tx_dr), .tx_done(tx_done), .busy(busy), .grant_idx(grant_idx),
        .timeout_err(timeout_err), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grant_chk(input string tag, input int idx, input logic [7:0] data);
        int n = 0;
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << idx;
        while (tx_te !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_te"}, 32'(tx_te), 32'd1);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_dr"}, 32'(tx_dr), 32'(data));
        chk({tag, "_gidx"}, 32'(grant_idx), 32'(idx));
    endtask

    task automatic finish_tx(input int delay);
        repeat (delay) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_te"}, 32'(tx_te), 32'd0);
        chk({tag, "_dr"}, 32'(tx_dr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_gidx"}, 32'(grant_idx), 32'd0);
        chk({tag, "_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_cnt"}, 32'(timeout_count), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        reset_n = 1'b0; enable = 1'b0; timeout_cycles = '0; tx_done = 1'b0;
        req = '0; req_last = '0; req_data = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        enable = 1'b1;
        // single byte
        req = 4'b0001; req_last = 4'b0001; req_data[7:0] = 8'h5A;
        @(negedge clk);
        chk("single_te", 32'(tx_te), 32'd1);
        chk("single_ack", 32'(ack), 32'b0001);
        chk("single_dr", 32'(tx_dr), 32'h5A);
        req = '0;
        @(negedge clk);
        chk("single_te_off", 32'(tx_te), 32'd0);
        chk("single_ack_off", 32'(ack), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        finish_tx(0);
        chk("single_busy_fall", 32'(busy), 32'd0);
        // round robin from reset
        do_reset();
        req = 4'hF; req_last = 4'hF; req_data = 32'hA3A2A1A0;
        for (int i = 0; i < 5; i++) begin
            grant_chk($sformatf("rr%0d", i), i % 4, 8'hA0 + 8'(i % 4));
            finish_tx(9);
        end
        // lock: requester 2 sends three bytes
        req = 4'b0100; req_last = 4'b1011; req_data[23:16] = 8'h21;
        grant_chk("lock0", 2, 8'h21);
        req = 4'hF; req_data[23:16] = 8'h22;
        finish_tx(4);
        grant_chk("lock1", 2, 8'h22);
        req_data[23:16] = 8'h23; req_last = 4'hF;
        finish_tx(4);
        grant_chk("lock2", 2, 8'h23);
        finish_tx(4);
        grant_chk("lock3", 3, 8'hA3);
        finish_tx(4);
        grant_chk("lock4", 0, 8'hA0);
        finish_tx(4);
        grant_chk("lock5", 1, 8'hA1);
        req = '0;
        finish_tx(4);
        // lock release when the locked requester drops req
        req = 4'b0010; req_last = 4'b1101; req_data[15:8] = 8'h11;
        grant_chk("drop0", 1, 8'h11);
        req = 4'b1000; req_last = 4'hF; req_data[31:24] = 8'h33;
        finish_tx(4);
        grant_chk("drop1", 3, 8'h33);
        req = 4'b0011;
        finish_tx(4);
        grant_chk("drop2", 0, 8'hA0);
        req = '0;
        finish_tx(4);
        // watchdog expiry
        timeout_cycles = 24'd20;
        req = 4'b0010; req_data[15:8] = 8'h55;
        grant_chk("wd0", 1, 8'h55);
        req = 4'b0100; req_data[23:16] = 8'h66;
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wd_delay", 32'(n), 32'd21);
        chk("wd_count", 32'(timeout_count), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        grant_chk("wd_next", 2, 8'h66);
        req = '0;
        // tx_done coincident with expiry wins
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= timeout_err;
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        seen |= timeout_err;
        @(negedge clk);
        seen |= timeout_err;
        chk("wd_coinc_err", 32'(seen), 32'd0);
        chk("wd_coinc_count", 32'(timeout_count), 32'd1);
        chk("wd_coinc_busy", 32'(busy), 32'd0);
        // enable dropped during WAIT_DONE
        req = 4'b1000; req_data[31:24] = 8'h77;
        grant_chk("en0", 3, 8'h77);
        enable = 1'b0; req = 4'hF;
        finish_tx(3);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= tx_te;
        end
        chk("en_no_grant", 32'(seen), 32'd0);
        chk("en_busy", 32'(busy), 32'd0);
        chk("en_dr_hold", 32'(tx_dr), 32'h77);
        // reset mid WAIT_DONE
        enable = 1'b1;
        grant_chk("rst0", 0, 8'hA0);
        repeat (3) @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter in `uart_controller_top` between `NUM_REQ` byte sources. It drives `tx_te`/`tx_dr` and waits for `tx_done` before issuing the next byte. A requester may lock the transmitter for a multi-byte message. A programmable watchdog recovers the arbiter if `tx_done` never arrives.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters.
- `REQ_IDX_WIDTH`, default 2: width of `grant_idx`; must satisfy `2**REQ_IDX_WIDTH >= NUM_REQ`.
- `TIMEOUT_WIDTH`, default 24: width of the watchdog counter and `timeout_cycles`.

Ports:
- `clk`  in  1: single clock. All logic uses the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: allows new grants.
- `timeout_cycles`  in  TIMEOUT_WIDTH: watchdog limit in cycles. 0 disables the watchdog.
- `req`  in  NUM_REQ: per-requester byte-pending flag.
- `req_last`  in  NUM_REQ: 1 means the presented byte ends that requester's message.
- `req_data`  in  NUM_REQ*8: byte for requester i is at `[8i+7:8i]`.
- `ack`  out  NUM_REQ: one-hot, 1-cycle pulse meaning the byte was taken.
- `tx_te`  out  1: 1-cycle transmit strobe to `uart_tx`.
- `tx_dr`  out  8: byte to `uart_tx`.
- `tx_done`  in  1: completion pulse from `uart_tx`.
- `busy`  out  1: high in ISSUE and WAIT_DONE.
- `grant_idx`  out  REQ_IDX_WIDTH: index of the most recent grant.
- `timeout_err`  out  1: 1-cycle pulse on watchdog expiry.
- `timeout_count`  out  8: watchdog expiries, saturating at 255.

## Operation
- Three states: IDLE, ISSUE, WAIT_DONE. The reset state is IDLE.

IDLE
- Nothing happens while `enable` is 0.
- With `enable` high:
  - If `lock` is set and `req[lock_idx]` is 1, requester `lock_idx` is granted.
  - If `lock` is set and `req[lock_idx]` is 0, `lock` clears and normal arbitration runs in the same cycle.
  - Otherwise, the first set `req` bit found scanning upward from `(last_grant+1) mod NUM_REQ` is granted.
- On a grant, all of the following happen:
  - `tx_dr` is loaded with the requester's byte.
  - `tx_te` and `ack[i]` are set.
  - `last_grant` and `grant_idx` are set to i.
  - The requester's `req_last[i]` value is captured.
  - The state moves to ISSUE.

ISSUE
- Lasts exactly one cycle: `tx_te` and `ack` clear, and the state moves to WAIT_DONE.
- The watchdog counter clears.

WAIT_DONE
- On `tx_done`: the state moves to IDLE.
  - If the captured `req_last` is 0, `lock` is set and `lock_idx` is set to i.
  - If it is 1, `lock` clears.
- Watchdog, when `timeout_cycles` is nonzero: the counter increments each cycle. When it reaches `timeout_cycles`, the arbiter does all of the following:
  - pulses `timeout_err`
  - increments `timeout_count`, saturating at 255
  - clears `lock`
  - moves to IDLE
- If `tx_done` arrives in the same cycle as expiry, `tx_done` wins: no error is raised.
- `enable` is ignored; an in-flight byte always completes or times out.

General rules
- `tx_done` outside WAIT_DONE is ignored.
- `req`/`req_data` are sampled only in IDLE. A requester must present its next byte, or drop `req`, in the cycle after `ack`.
- Reset values: all outputs 0 (`tx_dr`=0, `grant_idx`=0, `timeout_count`=0), `lock`=0, `last_grant`=NUM_REQ-1 so requester 0 wins first.
- Asserting reset mid-transfer returns the arbiter to IDLE immediately. The `uart_tx` reset is the integrator's responsibility.

## Timing
- The grant decision is made in cycle N while in IDLE with `req` visible.
- In cycle N+1, `tx_te`, `ack[i]` and `tx_dr` are all valid together for one cycle.
- If `tx_done` is seen in cycle M (WAIT_DONE), the state is IDLE in cycle M+1. The earliest next `tx_te` is cycle M+2.
- Minimum spacing between `tx_te` pulses is 3 cycles plus the UART frame time.
- `timeout_err` is high in the cycle after the counter reaches `timeout_cycles`, which is `timeout_cycles+1` cycles after ISSUE.
- `busy` is a registered state decode: high from cycle N+1 until the IDLE return.
- All outputs are registered.

## Test plan
- Reset and single byte:
  - Stimulus: `req`=0001, data 0x5A, `req_last`=1.
  - Required: `tx_te` and `ack`=0001 one cycle later with `tx_dr`=0x5A. After `tx_done`, `busy` falls the next cycle.
- Round robin:
  - Stimulus: `req`=1111 held, all `req_last`=1, `tx_done` returned 10 cycles after each `tx_te`.
  - Required: grant order 0,1,2,3,0 and `grant_idx` tracks it.
- Lock:
  - Stimulus: requester 2 sends 3 bytes with `req_last`=0,0,1 while `req`=1111.
  - Required: three consecutive grants to 2, then 3, 0, 1.
- Lock release on drop:
  - Stimulus: requester 1 sends byte 0x11 with `req_last`=0, then drops `req`; requester 3 is pending.
  - Required: requester 3 is granted in the next IDLE and `lock` is cleared.
- Watchdog:
  - Stimulus: `timeout_cycles`=20, `tx_done` withheld.
  - Required: `timeout_err` pulses 21 cycles after `tx_te`, `timeout_count`=1, the next requester is granted.
  - Repeat with `tx_done` coincident with expiry: no error.
- Enable and reset:
  - Stimulus: deassert `enable` during WAIT_DONE.
  - Required: the byte completes and there are no further grants.
  - Stimulus: assert `reset_n`=0 mid WAIT_DONE.
  - Required: all outputs read 0 within the same cycle.
